// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the i2c bus arbiter: i2c command codes and arbiter states.
package i2c_arb_pkg;

  localparam logic [2:0] k_cmd_start   = 3'd0;
  localparam logic [2:0] k_cmd_wr      = 3'd1;
  localparam logic [2:0] k_cmd_rd      = 3'd2;
  localparam logic [2:0] k_cmd_stop    = 3'd3;
  localparam logic [2:0] k_cmd_restart = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_OWN        = 3'd1,
    S_CMD        = 3'd2,
    S_ABORT      = 3'd3,
    S_ABORT_WAIT = 3'd4
  } arb_state_e;

  // A transaction counts as opened on the bus once a START has been issued.
  function automatic logic is_start(input logic [2:0] cmd);
    return cmd == k_cmd_start;
  endfunction

endpackage

// File: rtl/i2c_arb_if.sv
// Client-side and core-side signals of the i2c arbiter bundled into one interface.
// The master modport is the arbiter's view; the slave modport is the clients' and core's view.
interface i2c_arb_if #(
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_write;
  logic [3*N_REQ-1:0] req_cmd;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   req_done;
  logic [N_REQ-1:0]   req_abort;
  logic [7:0]         rd_data;
  logic               rd_ack;

  logic               core_write;
  logic [2:0]         core_cmd;
  logic [7:0]         core_data;
  logic               core_ready;
  logic [7:0]         core_data_out;
  logic               core_ack;
  logic               core_done_tick;

  modport master (
    input  req, req_write, req_cmd, req_data,
    input  core_ready, core_data_out, core_ack, core_done_tick,
    output gnt, req_done, req_abort, rd_data, rd_ack,
    output core_write, core_cmd, core_data
  );

  modport slave (
    output req, req_write, req_cmd, req_data,
    output core_ready, core_data_out, core_ack, core_done_tick,
    input  gnt, req_done, req_abort, rd_data, rd_ack,
    input  core_write, core_cmd, core_data
  );

endinterface

// File: rtl/i2c_arb_rr_pick.sv
// Combinational round-robin selector: first active request after `last`, wrapping around.
module i2c_arb_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  // Scan the requesters starting just after the previous owner so every client gets a turn.
  always_comb begin
    int cand;
    logic found;
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last) + k) % N_REQ;
      if (!found && req[cand]) begin
        found         = 1'b1;
        onehot[cand]  = 1'b1;
        index         = IDX_W'(cand);
      end
    end
    valid = found;
  end

endmodule

// File: rtl/i2c_arb.sv
// Round-robin arbiter sharing one i2c core between N_REQ sequencer clients.
// Ownership lasts from grant until the owner's STOP completes; a watchdog forces a STOP
// when the owner stalls or abandons an opened transaction.
module i2c_arb
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMER_W = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic      clk,
  input  logic      reset,
  i2c_arb_if.master bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   req_done_q, req_done_d;
  logic [N_REQ-1:0]   req_abort_q, req_abort_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               started_q, started_d;
  logic               stop_pend_q, stop_pend_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               core_write_q, core_write_d;
  logic [2:0]         core_cmd_q, core_cmd_d;
  logic [7:0]         core_data_q, core_data_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_ack_q, rd_ack_d;

  logic [N_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic               owner_req;
  logic               owner_wr;
  logic [2:0]         owner_cmd;
  logic [7:0]         owner_data;
  logic               owner_go;
  logic               timeout_hit;

  i2c_arb_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  // Select the current owner's request, strobe, command and byte; other clients are invisible.
  always_comb begin
    owner_req  = 1'b0;
    owner_wr   = 1'b0;
    owner_cmd  = '0;
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req  = bus.req[i];
        owner_wr   = bus.req_write[i];
        owner_cmd  = bus.req_cmd[3*i +: 3];
        owner_data = bus.req_data[8*i +: 8];
      end
    end
  end

  assign owner_go    = owner_wr && bus.core_ready;
  assign timeout_hit = (timer_q == TIMER_W'(TIMEOUT - 1));

  // State register plus all registered outputs and bookkeeping flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      req_done_q   <= '0;
      req_abort_q  <= '0;
      owner_q      <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      started_q    <= 1'b0;
      stop_pend_q  <= 1'b0;
      timer_q      <= '0;
      core_write_q <= 1'b0;
      core_cmd_q   <= '0;
      core_data_q  <= '0;
      rd_data_q    <= '0;
      rd_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      req_done_q   <= req_done_d;
      req_abort_q  <= req_abort_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      started_q    <= started_d;
      stop_pend_q  <= stop_pend_d;
      timer_q      <= timer_d;
      core_write_q <= core_write_d;
      core_cmd_q   <= core_cmd_d;
      core_data_q  <= core_data_d;
      rd_data_q    <= rd_data_d;
      rd_ack_q     <= rd_ack_d;
    end
  end

  // Next-state logic: an owner holds the bus until its STOP (own or forced) completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid && bus.core_ready) state_d = S_OWN;
      end
      S_OWN: begin
        if (!owner_req)                           state_d = started_q ? S_ABORT : S_IDLE;
        else if (owner_go)                        state_d = S_CMD;
        else if (bus.core_ready && timeout_hit)   state_d = S_ABORT;
      end
      S_CMD: begin
        if (bus.core_done_tick) state_d = stop_pend_q ? S_IDLE : S_OWN;
      end
      S_ABORT: begin
        if (bus.core_ready) state_d = S_ABORT_WAIT;
      end
      S_ABORT_WAIT: begin
        if (bus.core_done_tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic: grant, command forwarding, result routing and the watchdog.
  always_comb begin
    gnt_d        = gnt_q;
    req_done_d   = '0;
    req_abort_d  = '0;
    owner_d      = owner_q;
    last_d       = last_q;
    started_d    = started_q;
    stop_pend_d  = stop_pend_q;
    timer_d      = timer_q;
    core_write_d = 1'b0;
    core_cmd_d   = core_cmd_q;
    core_data_d  = core_data_q;
    rd_data_d    = rd_data_q;
    rd_ack_d     = rd_ack_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid && bus.core_ready) begin
          gnt_d       = pick_onehot;
          owner_d     = pick_idx;
          started_d   = 1'b0;
          stop_pend_d = 1'b0;
          timer_d     = '0;
        end
      end
      S_OWN: begin
        if (!owner_req) begin
          if (!started_q) begin
            gnt_d  = '0;
            last_d = owner_q;
          end
        end else if (owner_go) begin
          core_write_d = 1'b1;
          core_cmd_d   = owner_cmd;
          core_data_d  = owner_data;
          started_d    = started_q | is_start(owner_cmd);
          stop_pend_d  = (owner_cmd == k_cmd_stop);
        end else if (bus.core_ready && !timeout_hit) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_CMD: begin
        if (bus.core_done_tick) begin
          req_done_d = gnt_q;
          rd_data_d  = bus.core_data_out;
          rd_ack_d   = bus.core_ack;
          if (stop_pend_q) begin
            gnt_d  = '0;
            last_d = owner_q;
          end else begin
            timer_d = '0;
          end
        end
      end
      S_ABORT: begin
        if (bus.core_ready) begin
          core_write_d = 1'b1;
          core_cmd_d   = k_cmd_stop;
        end
      end
      S_ABORT_WAIT: begin
        if (bus.core_done_tick) begin
          req_abort_d = gnt_q;
          gnt_d       = '0;
          last_d      = owner_q;
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  assign bus.gnt        = gnt_q;
  assign bus.req_done   = req_done_q;
  assign bus.req_abort  = req_abort_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.core_write = core_write_q;
  assign bus.core_cmd   = core_cmd_q;
  assign bus.core_data  = core_data_q;

endmodule
